// File: rtl/fmov_rs.sv
// Reservation station for FPU sign-move ops (fmov/fneg/fabs/fnabs): wakes on CDB snoop and dispatches oldest-ready.
// Optional flush port and behaviour enabled by defining FMOV_RS_FLUSH_EN.
module fmov_rs #(
  parameter int N_ENTRY   = 4,
  parameter int N_CDB     = 2,
  parameter int ROB_WIDTH = 5,
  parameter int DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [1:0]                    issue_op,
  input  logic [ROB_WIDTH-1:0]          issue_tag,
  input  logic                          opd_valid,
  input  logic [ROB_WIDTH-1:0]          opd_tag,
  input  logic [DATA_W-1:0]             opd_data,
  input  logic [N_CDB-1:0]              cdb_valid,
  input  logic [N_CDB*ROB_WIDTH-1:0]    cdb_tag,
  input  logic [N_CDB*DATA_W-1:0]       cdb_data,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [ROB_WIDTH-1:0]          req_tag,
  output logic [DATA_W-1:0]             result,
  output logic [$clog2(N_ENTRY+1)-1:0]  occupancy
`ifdef FMOV_RS_FLUSH_EN
  ,
  input  logic                          flush
`endif
);

  localparam int SEL_W = $clog2(N_ENTRY + 1);
  localparam int OCC_W = $clog2(N_ENTRY + 1);

  typedef struct packed {
    logic                 rdy;
    logic [1:0]           op;
    logic [ROB_WIDTH-1:0] tag;
    logic [ROB_WIDTH-1:0] src;
    logic [DATA_W-1:0]    data;
  } ent_t;

  logic flush_w;
`ifdef FMOV_RS_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] sign_rule(input logic [1:0] op, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = d;
    case (op)
      2'b01:   r[DATA_W-1] = ~d[DATA_W-1];
      2'b10:   r[DATA_W-1] = 1'b0;
      2'b11:   r[DATA_W-1] = 1'b1;
      default: r[DATA_W-1] = d[DATA_W-1];
    endcase
    return r;
  endfunction

  // Descending scan so the lowest-numbered matching bus is the one that sticks.
  function automatic ent_t wake(input ent_t e, input logic [N_CDB-1:0] cv,
                                input logic [N_CDB*ROB_WIDTH-1:0] ct,
                                input logic [N_CDB*DATA_W-1:0] cd);
    ent_t r;
    r = e;
    if (!e.rdy) begin
      for (int c = N_CDB - 1; c >= 0; c--) begin
        if (cv[c] && ct[c*ROB_WIDTH +: ROB_WIDTH] == e.src) begin
          r.rdy  = 1'b1;
          r.data = sign_rule(e.op, cd[c*DATA_W +: DATA_W]);
        end
      end
    end
    return r;
  endfunction

  ent_t                 ent_p0 [N_ENTRY];
  logic [N_ENTRY-1:0]   vld_p0;
  logic [DATA_W-1:0]    result_p1;

  ent_t                 upd [N_ENTRY];
  ent_t                 in_ent;
  ent_t                 ext [N_ENTRY+1];
  logic [N_ENTRY:0]     ext_vld;
  ent_t                 nxt [N_ENTRY];
  logic [N_ENTRY-1:0]   nxt_vld;
  logic [OCC_W-1:0]     occ_n;
  logic                 found;
  logic [SEL_W-1:0]     sel;
  logic [ROB_WIDTH-1:0] sel_tag;
  logic [DATA_W-1:0]    sel_data;
  logic                 dispatch;
  logic                 bypass;
  logic                 in_acc;
  logic                 placed;

  // Stage p0: wakeup and oldest-ready selection over stored entries then the incoming issue
  always_comb begin
    for (int i = 0; i < N_ENTRY; i++) upd[i] = wake(ent_p0[i], cdb_valid, cdb_tag, cdb_data);
    in_ent.rdy  = opd_valid;
    in_ent.op   = issue_op;
    in_ent.tag  = issue_tag;
    in_ent.src  = opd_tag;
    in_ent.data = sign_rule(issue_op, opd_data);
    in_ent      = wake(in_ent, cdb_valid, cdb_tag, cdb_data);

    found    = 1'b0;
    sel      = '0;
    sel_tag  = '0;
    sel_data = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      if (!found && vld_p0[i] && upd[i].rdy) begin
        found    = 1'b1;
        sel      = SEL_W'(i);
        sel_tag  = upd[i].tag;
        sel_data = upd[i].data;
      end
    end
    if (!found && issue_valid && in_ent.rdy) begin
      found    = 1'b1;
      sel      = SEL_W'(N_ENTRY);
      sel_tag  = in_ent.tag;
      sel_data = in_ent.data;
    end
  end

  assign req_valid   = found && !flush_w;
  assign req_tag     = sel_tag;
  assign dispatch    = req_valid && req_ready;
  assign bypass      = dispatch && (sel == SEL_W'(N_ENTRY));
  assign issue_ready = !flush_w && (dispatch || !vld_p0[N_ENTRY-1]);
  assign in_acc      = issue_valid && issue_ready && !bypass;
  assign result      = result_p1;

  // Accepted issue lands in the first free slot (slot N_ENTRY when full), then the removal shift closes the gap.
  always_comb begin
    placed = 1'b0;
    for (int k = 0; k < N_ENTRY; k++) begin
      ext[k]     = upd[k];
      ext_vld[k] = vld_p0[k];
      if (!vld_p0[k] && !placed) begin
        ext[k]     = in_ent;
        ext_vld[k] = in_acc;
        placed     = 1'b1;
      end
    end
    ext[N_ENTRY]     = in_ent;
    ext_vld[N_ENTRY] = in_acc && !placed;

    occ_n = '0;
    for (int k = 0; k < N_ENTRY; k++) begin
      if (dispatch && !bypass && int'(sel) <= k) begin
        nxt[k]     = ext[k+1];
        nxt_vld[k] = ext_vld[k+1];
      end else begin
        nxt[k]     = ext[k];
        nxt_vld[k] = ext_vld[k];
      end
      if (flush_w) nxt_vld[k] = 1'b0;
      occ_n = occ_n + OCC_W'(nxt_vld[k]);
    end
  end

  // Stage p1: entry state, occupancy and dispatched result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0    <= '0;
      occupancy <= '0;
      result_p1 <= '0;
    end else begin
      vld_p0    <= nxt_vld;
      occupancy <= occ_n;
      if (dispatch) result_p1 <= sel_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_ENTRY; k++) ent_p0[k] <= nxt[k];
  end

endmodule

// File: tb/tb_fmov_rs.sv
// Randomized plus directed bench for fmov_rs against a queue-based behavioural model.
// Flush scenario is exercised when FMOV_RS_FLUSH_EN is defined.
module tb_fmov_rs;
  localparam int N  = 4;
  localparam int NC = 2;
  localparam int RW = 5;
  localparam int DW = 32;
  localparam int OW = $clog2(N + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              issue_valid, issue_ready, opd_valid, req_valid, req_ready, flush;
  logic [1:0]        issue_op;
  logic [RW-1:0]     issue_tag, opd_tag, req_tag;
  logic [DW-1:0]     opd_data, result;
  logic [NC-1:0]     cdb_valid;
  logic [NC*RW-1:0]  cdb_tag;
  logic [NC*DW-1:0]  cdb_data;
  logic [OW-1:0]     occupancy;

  int n_cmp = 0;
  int n_err = 0;

  fmov_rs #(.N_ENTRY(N), .N_CDB(NC), .ROB_WIDTH(RW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_tag(issue_tag), .opd_valid(opd_valid), .opd_tag(opd_tag),
    .opd_data(opd_data), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .result(result),
    .occupancy(occupancy)
`ifdef FMOV_RS_FLUSH_EN
    , .flush(flush)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] tag;
    logic [RW-1:0] src;
    logic [1:0]    op;
    bit            rdy;
    logic [DW-1:0] data;
  } m_ent_t;

  m_ent_t        mq[$];
  logic [DW-1:0] m_result = '0;
  logic [DW-1:0] m_in_data;
  logic [RW-1:0] m_req_tag;
  bit            m_in_rdy, m_req_valid, m_disp, m_issue_ready;
  int            m_sel;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // neg flips the sign, abs forces it to the neg bit
  function automatic logic [DW-1:0] ref_sign(input logic [1:0] op, input logic [DW-1:0] d);
    logic s;
    s = op[1] ? op[0] : (d[DW-1] ^ op[0]);
    return {s, d[DW-2:0]};
  endfunction

  function automatic bit cdb_hit(input logic [RW-1:0] t, output logic [DW-1:0] d);
    d = '0;
    for (int i = 0; i < NC; i++)
      if (cdb_valid[i] && cdb_tag[i*RW +: RW] == t) begin
        d = cdb_data[i*DW +: DW];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model_eval();
    logic [DW-1:0] d;
    foreach (mq[i])
      if (!mq[i].rdy && cdb_hit(mq[i].src, d)) begin
        mq[i].rdy  = 1'b1;
        mq[i].data = ref_sign(mq[i].op, d);
      end
    m_in_rdy  = opd_valid;
    m_in_data = ref_sign(issue_op, opd_data);
    if (!opd_valid && cdb_hit(opd_tag, d)) begin
      m_in_rdy  = 1'b1;
      m_in_data = ref_sign(issue_op, d);
    end
    m_sel = -1;
    foreach (mq[i]) if (m_sel < 0 && mq[i].rdy) m_sel = i;
    if (m_sel < 0 && issue_valid && m_in_rdy) m_sel = N;
    m_req_tag = '0;
    if (m_sel == N) m_req_tag = issue_tag;
    else if (m_sel >= 0) m_req_tag = mq[m_sel].tag;
    m_req_valid   = (m_sel >= 0) && !flush;
    m_disp        = m_req_valid && req_ready;
    m_issue_ready = !flush && (m_disp || mq.size() < N);
  endtask

  task automatic model_commit();
    m_ent_t e;
    if (m_disp) begin
      if (m_sel == N) m_result = m_in_data;
      else begin
        m_result = mq[m_sel].data;
        mq.delete(m_sel);
      end
    end
    if (issue_valid && m_issue_ready && !(m_disp && m_sel == N)) begin
      e.tag = issue_tag; e.src = opd_tag; e.op = issue_op;
      e.rdy = m_in_rdy;  e.data = m_in_data;
      mq.push_back(e);
    end
    if (flush) mq.delete();
  endtask

  task automatic eval_chk();
    #1;
    model_eval();
    check_eq("req_valid", req_valid, m_req_valid);
    if (m_req_valid) check_eq("req_tag", req_tag, m_req_tag);
    check_eq("issue_ready", issue_ready, m_issue_ready);
  endtask

  task automatic commit_chk();
    @(posedge clk);
    model_commit();
    #1;
    check_eq("result", result, m_result);
    check_eq("occupancy", occupancy, mq.size());
    @(negedge clk);
  endtask

  task automatic cycle();
    eval_chk();
    commit_chk();
  endtask

  task automatic set_issue(input bit v, input logic [1:0] op, input logic [RW-1:0] tag,
                           input bit ov, input logic [RW-1:0] ot, input logic [DW-1:0] od);
    issue_valid = v; issue_op = op; issue_tag = tag;
    opd_valid = ov; opd_tag = ot; opd_data = od;
  endtask

  task automatic set_cdb(input int bus, input logic [RW-1:0] t, input logic [DW-1:0] d);
    cdb_valid[bus] = 1'b1;
    cdb_tag[bus*RW +: RW] = t;
    cdb_data[bus*DW +: DW] = d;
  endtask

  task automatic idle(input bit rr);
    set_issue(1'b0, 2'b00, '0, 1'b0, '0, '0);
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    req_ready = rr; flush = 1'b0;
  endtask

  task automatic fill_waiting(input int n, input logic [RW-1:0] tag0, input logic [RW-1:0] src0);
    for (int i = 0; i < n; i++) begin
      idle(1'b0);
      set_issue(1'b1, 2'b00, tag0 + RW'(i), 1'b0, src0 + RW'(i), '0);
      cycle();
    end
    idle(1'b0);
  endtask

  task automatic reset_mid();
    idle(1'b0);
    reset = 1'b1;
    #1;
    mq.delete();
    m_result = '0;
    check_eq("rst_occupancy", occupancy, 0);
    check_eq("rst_req_valid", req_valid, 0);
    check_eq("rst_issue_ready", issue_ready, 1);
    check_eq("rst_result", result, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [RW-1:0] exp_ord [3];

  initial begin
    reset = 1'b1;
    idle(1'b0);
    repeat (2) @(negedge clk);
    check_eq("init_occupancy", occupancy, 0);
    check_eq("init_req_valid", req_valid, 0);
    check_eq("init_issue_ready", issue_ready, 1);
    check_eq("init_result", result, 0);
    reset = 1'b0;
    @(negedge clk);

    // pass-through fneg on an empty station
    idle(1'b1);
    set_issue(1'b1, 2'b01, 5'd2, 1'b1, '0, 32'h3F800000);
    eval_chk();
    check_eq("t1_req_valid", req_valid, 1);
    commit_chk();
    check_eq("t1_result", result, 32'hBF800000);
    check_eq("t1_occupancy", occupancy, 0);

    // fabs woken by CDB1, dispatched in the wake cycle
    idle(1'b1);
    set_issue(1'b1, 2'b10, 5'd3, 1'b0, 5'd7, '0);
    cycle();
    idle(1'b1);
    set_cdb(1, 5'd7, 32'hC0000000);
    eval_chk();
    check_eq("t2_req_tag", req_tag, 3);
    commit_chk();
    check_eq("t2_result", result, 32'h40000000);

    // full station, out-of-order wake, then age-ordered drain
    fill_waiting(4, 5'd1, 5'd11);
    eval_chk();
    check_eq("t3_full_issue_ready", issue_ready, 0);
    commit_chk();
    idle(1'b1);
    set_cdb(0, 5'd13, 32'h00000003);
    eval_chk();
    check_eq("t3_req_tag", req_tag, 3);
    check_eq("t3_issue_ready", issue_ready, 1);
    commit_chk();
    idle(1'b0);
    set_cdb(0, 5'd11, 32'h00000001);
    set_cdb(1, 5'd12, 32'h00000002);
    cycle();
    idle(1'b0);
    set_cdb(0, 5'd14, 32'h00000004);
    cycle();
    exp_ord[0] = 5'd1; exp_ord[1] = 5'd2; exp_ord[2] = 5'd4;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      eval_chk();
      check_eq("t3_order", req_tag, exp_ord[i]);
      commit_chk();
    end

    // full + dispatch + issue in one cycle
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      set_issue(1'b1, 2'b00, 5'd5 + RW'(i), 1'b1, '0, 32'h10 + DW'(i));
      cycle();
    end
    idle(1'b1);
    set_issue(1'b1, 2'b11, 5'd9, 1'b1, '0, 32'h00000020);
    eval_chk();
    check_eq("t4_issue_ready", issue_ready, 1);
    check_eq("t4_req_tag", req_tag, 5);
    commit_chk();
    check_eq("t4_occupancy", occupancy, 4);
    idle(1'b1);
    repeat (4) cycle();

    // same tag on both buses: bus 0 wins
    idle(1'b1);
    set_issue(1'b1, 2'b00, 5'd5, 1'b0, 5'd6, '0);
    cycle();
    idle(1'b1);
    set_cdb(0, 5'd6, 32'h00000001);
    set_cdb(1, 5'd6, 32'h00000002);
    cycle();
    check_eq("t5_result", result, 32'h00000001);

    // reset with three ops in flight
    fill_waiting(3, 5'd20, 5'd20);
    check_eq("t6_pre_occupancy", occupancy, 3);
    reset_mid();

`ifdef FMOV_RS_FLUSH_EN
    fill_waiting(3, 5'd20, 5'd20);
    idle(1'b1);
    flush = 1'b1;
    set_issue(1'b1, 2'b00, 5'd1, 1'b1, '0, 32'h5);
    cycle();
    check_eq("flush_occupancy", occupancy, 0);
    idle(1'b1);
`endif

    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) reset_mid();
      idle($urandom_range(0, 3) != 0);
      set_issue($urandom_range(0, 1), 2'($urandom_range(0, 3)), RW'($urandom_range(0, 31)),
                $urandom_range(0, 1), RW'($urandom_range(0, 7)), $urandom);
      for (int b = 0; b < NC; b++)
        if ($urandom_range(0, 2) == 0) set_cdb(b, RW'($urandom_range(0, 7)), $urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
